// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection scan controller.
package edge_pkg;

  localparam int unsigned KERNEL_TAPS = 9;
  localparam int unsigned MIN_DIM     = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_REQ,
    WAIT_RES,
    WR_REQ,
    NEXT,
    FINISH
  } scan_state_t;

  // Command from the FSM to the window counter, applied at the next edge.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INIT,
    CNT_TAP,
    CNT_STEP
  } cnt_cmd_t;

endpackage

// File: rtl/edge_scan_ctrl_if.sv
// Single-outstanding memory port between the scan controller and memory.
interface edge_scan_ctrl_if #(
  parameter int PIX_W = 8
);
  logic             mreq;
  logic             mwrite;
  logic [31:0]      maddr;
  logic [PIX_W-1:0] mwdata;
  logic [PIX_W-1:0] mrdata;
  logic             mready;

  modport master (
    output mreq, mwrite, maddr, mwdata,
    input  mrdata, mready
  );

  modport slave (
    input  mreq, mwrite, maddr, mwdata,
    output mrdata, mready
  );
endinterface

// File: rtl/edge_win_counter.sv
// Window position / tap counters with incremental row bases; produces the
// address that the request registers should carry after the next edge.
module edge_win_counter
  import edge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  cnt_cmd_t    cmd,
  input  logic [15:0] width,
  input  logic [15:0] height,
  input  logic [31:0] raddr_base,
  input  logic [31:0] waddr_base,
  output logic [31:0] rd_addr_nxt,
  output logic [31:0] wr_addr_nxt,
  output logic [3:0]  tap,
  output logic        last_tap,
  output logic        last_win
);

  logic [15:0] x, y, x_n, y_n;
  logic [3:0]  tap_n;
  logic [1:0]  r, c, r_n, c_n;
  logic [31:0] rd_row, tap_row, wr_row;
  logic [31:0] rd_row_n, tap_row_n, wr_row_n;
  logic [31:0] w32;
  logic        x_more, y_more;

  assign w32      = {16'b0, width};
  assign x_more   = x < (width - 16'd2);
  assign y_more   = y < (height - 16'd2);
  assign last_tap = tap == 4'(KERNEL_TAPS - 1);
  assign last_win = !x_more && !y_more;

  // Addresses are taken from next-state values so the top can register them
  // in the same edge that moves the counters.
  assign rd_addr_nxt = tap_row_n + {16'b0, x_n} + {30'b0, c_n} - 32'd1;
  assign wr_addr_nxt = wr_row_n + {16'b0, x_n};

  // Next-state computation for counters and row bases.
  always_comb begin
    x_n       = x;
    y_n       = y;
    tap_n     = tap;
    r_n       = r;
    c_n       = c;
    rd_row_n  = rd_row;
    tap_row_n = tap_row;
    wr_row_n  = wr_row;
    case (cmd)
      CNT_INIT: begin
        x_n       = 16'd1;
        y_n       = 16'd1;
        tap_n     = '0;
        r_n       = '0;
        c_n       = '0;
        rd_row_n  = raddr_base;
        tap_row_n = raddr_base;
        wr_row_n  = waddr_base + w32;
      end
      CNT_TAP: begin
        tap_n = tap + 4'd1;
        if (c == 2'd2) begin
          c_n       = '0;
          r_n       = r + 2'd1;
          tap_row_n = tap_row + w32;
        end else begin
          c_n = c + 2'd1;
        end
      end
      CNT_STEP: begin
        tap_n = '0;
        r_n   = '0;
        c_n   = '0;
        if (x_more) begin
          x_n       = x + 16'd1;
          tap_row_n = rd_row;
        end else begin
          x_n       = 16'd1;
          y_n       = y + 16'd1;
          rd_row_n  = rd_row + w32;
          tap_row_n = rd_row + w32;
          wr_row_n  = wr_row + w32;
        end
      end
      default: ;
    endcase
  end

  // Counter and row-base registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      tap     <= '0;
      r       <= '0;
      c       <= '0;
      rd_row  <= '0;
      tap_row <= '0;
      wr_row  <= '0;
    end else begin
      x       <= x_n;
      y       <= y_n;
      tap     <= tap_n;
      r       <= r_n;
      c       <= c_n;
      rd_row  <= rd_row_n;
      tap_row <= tap_row_n;
      wr_row  <= wr_row_n;
    end
  end

endmodule

// File: rtl/edge_scan_ctrl.sv
// Frame sequencer: walks interior pixels, fetches 3x3 windows, streams taps
// to the Sobel datapath and writes each result back to the output frame.
module edge_scan_ctrl
  import edge_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      img_width,
  input  logic [15:0]      img_height,
  input  logic [31:0]      start_raddr,
  input  logic [31:0]      start_waddr,
  edge_scan_ctrl_if.master mem,
  output logic             pix_valid,
  output logic [3:0]       pix_idx,
  output logic [PIX_W-1:0] pix_data,
  input  logic             res_valid,
  input  logic [PIX_W-1:0] res_data,
  output logic             busy,
  output logic             done
);

  scan_state_t state;
  cnt_cmd_t    cmd;
  logic [15:0] width, height;
  logic [31:0] raddr_base, waddr_base;
  logic [31:0] rd_addr_nxt, wr_addr_nxt;
  logic [3:0]  tap;
  logic        last_tap, last_win;
  logic        dims_ok, acc;

  assign dims_ok = (width >= 16'(MIN_DIM)) && (height >= 16'(MIN_DIM));
  assign acc     = mem.mready && mem.mreq;

  edge_win_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .width      (width),
    .height     (height),
    .raddr_base (raddr_base),
    .waddr_base (waddr_base),
    .rd_addr_nxt(rd_addr_nxt),
    .wr_addr_nxt(wr_addr_nxt),
    .tap        (tap),
    .last_tap   (last_tap),
    .last_win   (last_win)
  );

  // Counter command, timed so counters move in the same edge as the request registers.
  always_comb begin
    cmd = CNT_HOLD;
    case (state)
      SETUP:   if (dims_ok) cmd = CNT_INIT;
      RD_REQ:  if (acc && !last_tap) cmd = CNT_TAP;
      NEXT:    if (!last_win) cmd = CNT_STEP;
      default: ;
    endcase
  end

  // Sequencer FSM with registered memory, pixel and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      width      <= '0;
      height     <= '0;
      raddr_base <= '0;
      waddr_base <= '0;
      mem.mreq   <= 1'b0;
      mem.mwrite <= 1'b0;
      mem.maddr  <= '0;
      mem.mwdata <= '0;
      pix_valid  <= 1'b0;
      pix_idx    <= '0;
      pix_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            width      <= img_width;
            height     <= img_height;
            raddr_base <= start_raddr;
            waddr_base <= start_waddr;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (dims_ok) begin
            mem.mreq   <= 1'b1;
            mem.mwrite <= 1'b0;
            mem.maddr  <= rd_addr_nxt;
            state      <= RD_REQ;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        RD_REQ: begin
          if (acc) begin
            pix_valid <= 1'b1;
            pix_idx   <= tap;
            pix_data  <= mem.mrdata;
            if (last_tap) begin
              mem.mreq <= 1'b0;
              state    <= WAIT_RES;
            end else begin
              // mreq stays high: next tap is issued without a gap
              mem.maddr <= rd_addr_nxt;
            end
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            mem.mreq   <= 1'b1;
            mem.mwrite <= 1'b1;
            mem.maddr  <= wr_addr_nxt;
            mem.mwdata <= res_data;
            state      <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (acc) begin
            mem.mreq   <= 1'b0;
            mem.mwrite <= 1'b0;
            state      <= NEXT;
          end
        end
        NEXT: begin
          if (last_win) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            mem.mreq   <= 1'b1;
            mem.mwrite <= 1'b0;
            mem.maddr  <= rd_addr_nxt;
            state      <= RD_REQ;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/edge_scan_ctrl.md
# edge_scan_ctrl

Sequencing controller for the edge-detection accelerator. It takes the frame configuration latched by the AHB slave (`img_width`, `img_height`, `start_raddr`, `start_waddr`), walks every interior pixel of the image, and fetches each 3x3 window over a single-outstanding memory master port. It streams the nine pixels to the Sobel datapath, waits for the result, writes it to the output frame, and pulses `done` back to the slave at the end of the frame.

## Interface
Parameters:
- `PIX_W`, default 8: pixel width in bits. The image is byte-addressed, one pixel per address.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins a frame.
- `img_width`  in  16: frame width W, in pixels.
- `img_height`  in  16: frame height H, in pixels.
- `start_raddr`  in  32: base address of the source frame.
- `start_waddr`  in  32: base address of the destination frame.
- `mreq`  out  1: memory request.
- `mwrite`  out  1: 1 = write, 0 = read. Valid while `mreq` is high.
- `maddr`  out  32: memory address.
- `mwdata`  out  PIX_W: write data.
- `mrdata`  in  PIX_W: read data. Valid in the cycle `mready` is high.
- `mready`  in  1: single-cycle completion pulse for the current request.
- `pix_valid`  out  1: pixel strobe to the datapath.
- `pix_idx`  out  4: window tap index, 0..8.
- `pix_data`  out  PIX_W: window pixel.
- `res_valid`  in  1: datapath result strobe.
- `res_data`  in  PIX_W: datapath result.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: single-cycle end-of-frame pulse.

## Operation
- **Reset values.** All outputs reset to 0. The state machine resets to IDLE and the counters reset to 0.
- **States.** IDLE, SETUP, RD_REQ, WAIT_RES, WR_REQ, NEXT, FINISH.
- **IDLE.** On `start`: latch W, H and both base addresses, then go to SETUP. Changes on the configuration inputs after this point are ignored until the frame ends.
- **SETUP.**
  - If W < 3 or H < 3: go to FINISH. No memory access is made.
  - Otherwise set x = 1, y = 1, tap = 0, and go to RD_REQ.
- **RD_REQ.**
  - Drive `mreq` = 1, `mwrite` = 0, `maddr` = start_raddr + (y-1+tap/3)*W + (x-1+tap%3).
  - On `mready`: issue a one-cycle `pix_valid` the following cycle, with `pix_idx` = tap and `pix_data` = captured `mrdata`.
  - If tap = 8, go to WAIT_RES. Otherwise increment tap and stay in RD_REQ.
- **WAIT_RES.** Hold until `res_valid`, latch `res_data`, then go to WR_REQ.
- **WR_REQ.**
  - Drive `mreq` = 1, `mwrite` = 1, `maddr` = start_waddr + y*W + x, `mwdata` = latched result.
  - On `mready`, go to NEXT.
- **NEXT.**
  - If x < W-2: increment x.
  - Else if y < H-2: set x = 1 and increment y.
  - Else go to FINISH.
  - When not finishing, set tap = 0 and return to RD_REQ.
- **FINISH.** Pulse `done` for one cycle, drop `busy`, return to IDLE.
- **Border pixels.** Border pixels of the destination frame are never written.
- **Address arithmetic.** All address arithmetic is unsigned 32-bit and wraps modulo 2^32.
  - Row offsets are kept as incremental row-base registers, adding W per row; no multiplier is used.
  - tap/3 and tap%3 come from a 2-bit row counter and a 2-bit column counter, not a divider.
- **Start while busy.** `start` is ignored when the controller is not in IDLE.
- **Stray strobes.** `mready` is ignored while `mreq` is low. `res_valid` is ignored outside WAIT_RES.

## Timing
- **Request handshake.** `mreq`, `mwrite`, `maddr` and `mwdata` are registered. They stay stable from assertion until the cycle `mready` is high.
  - `mreq` falls in the cycle after `mready`.
  - Back-to-back reads re-assert `mreq` with the next address in that same following cycle, so there is no idle cycle between taps.
- **Per-pixel latency.** With `mready` returning 1 cycle after each request and `res_valid` returning 1 cycle after the last tap, one output pixel takes about 21 cycles.
- **start to first request.** `start` in cycle 0 gives `mreq` asserted in cycle 2.
- **Degenerate frame.** `start` with a degenerate frame gives `done` in cycle 2 and `mreq` never asserts.
- **Reset mid-frame.** `rst` asserted mid-frame immediately drops `mreq`, `pix_valid`, `busy` and `done`. No partial `done` is produced and the controller restarts in IDLE.

## Structure
- **Shared package `edge_pkg`:**
  - state enum `scan_state_t`;
  - `KERNEL_TAPS` = 9;
  - `MIN_DIM` = 3.
- **Sub-module `edge_win_counter`:** holds the x/y/tap counters and the incremental row-base registers, and produces the read and write addresses. The top module holds the FSM and the handshake logic.

## Test plan
- **3x3 frame.** W=3, H=3, start_raddr=0x1000, start_waddr=0x2000, `mready` 1 cycle after each request, `res_data`=0x5A -> nine reads at 0x1000, 0x1001, 0x1002, 0x1003, 0x1004, 0x1005, 0x1006, 0x1007, 0x1008 with `pix_idx` 0..8, then one write of 0x5A at 0x2004, then one `done` pulse.
- **4x4 frame.** W=4, H=4, same bases -> writes at 0x2005, 0x2006, 0x2009, 0x200A in that order. The first window of row y=2 reads from 0x1004.
- **Degenerate frame.** W=2, H=5 -> `mreq` stays 0 and `done` pulses 2 cycles after `start`.
- **Slow memory.** `mready` delayed 4 cycles -> `maddr` and `mreq` stay constant over those cycles, and only one `pix_valid` is produced per `mready`.
- **Start while busy.** A second `start` during RD_REQ with different config values -> ignored, and the addresses still use the first config.
- **Reset mid-frame.** Reset asserted during the third tap of a 5x5 frame -> all outputs are 0 immediately, no `done`. A subsequent `start` runs a full 3x3 frame correctly.
